int_alu_responder: RTL and testbench
====================================

Name: int_alu_responder

Overview:
- Bus-slave integer ALU that answers the memory-mapped protocol the execution engine and system benches use to drive it.
- Decodes `address[15:12] == IntAlu (5)` and latches two 256-bit source operands. It starts an operation when the opcode register is written and presents the result on `IntDataOut`.
- Data is 16 lanes × 16 bits, little-endian: lane 0 is bits [15:0].
- Sits on the shared bus beside main memory, register file and instruction memory.

Parameters:
- `SEL_ID`, 5, module-select value matched against `address[15:12]`.
- `LANES`, 16, number of lanes in a 256-bit word.
- `LANE_W`, 16, lane width in bits.

Ports:
- `Clk`  in  1  system clock, all state on rising edge.
- `Reset`  in  1  asynchronous, active-high; clears all state.
- `address`  in  16  [15:12] module select, [11:0] register offset.
- `nWrite`  in  1  active-low write strobe, sampled at `Clk` rising edge.
- `nRead`  in  1  active-low read strobe, sampled at `Clk` rising edge.
- `DataIn`  in  256  write data from the bus.
- `IntDataOut`  out  256  registered read/result data.
- `Busy`  out  1  high while an operation is in progress.
- `Done`  out  1  high from completion until the next accepted start.

Behaviour:
- Selected: `address[15:12] == SEL_ID`. An access is a write when selected and `nWrite==0`. It is a read when selected, `nWrite==1` and `nRead==0`. If both strobes are low, the write wins.
- Register offsets:
  - 0 = SRC1 (R/W).
  - 1 = SRC2 (R/W).
  - 2 = RESULT (RO).
  - 3 = CMD/STATUS: a write carries the opcode in `DataIn[7:0]`. A read returns status: [7:0] last opcode, [8] busy, [9] done, [10] error (sticky); all other bits 0.
- Other offsets: writes ignored; reads return 0.
- Reset values: SRC1, SRC2, RESULT, `IntDataOut` = 0; opcode = 0; `Busy`, `Done`, error = 0; state IDLE.
- Opcodes, all lane arithmetic modulo 2^16 with no carry or borrow between lanes:
  - 0x10 ADD: lane-wise `a + b`.
  - 0x11 SUB: lane-wise `a − b`.
  - 0x12 CONV: lane convolution, `r[k] = Σ a[i]·b[k−i]` for `i ≤ k`, k = 0..15; terms beyond lane 15 are discarded.
  - 0x13 MUL: lane-wise low 16 bits of `a·b`.
- State machine (IDLE, EXEC, CONV):
  - IDLE, write to offset 3:
    - Opcode 0x10, 0x11 or 0x13 → EXEC; `Busy` = 1, `Done` = 0.
    - Opcode 0x12 → CONV; counter = 0, accumulator = 0.
    - Any other opcode → stay in IDLE; RESULT = 0, `Done` = 1, error = 1.
  - EXEC, one cycle: RESULT and `IntDataOut` ← result; `Busy` = 0, `Done` = 1 → IDLE.
  - Latency: start write sampled at edge N; result visible after edge N+1.
  - CONV, each cycle: accumulator += (`a[cnt]` · each lane of `b`), shifted up by `cnt` lanes; `cnt` += 1.
    - After `cnt == 15` is processed: RESULT and `IntDataOut` ← accumulator; `Busy` = 0, `Done` = 1 → IDLE.
    - Latency: result visible after edge N+16.
- Operand use: SRC1 and SRC2 are read from their registers during execution; they are not snapshotted.
- Writes while `Busy`: writes to any offset are dropped and set the error bit. Reads remain serviced.
- Read timing: a read at edge N loads `IntDataOut` with the addressed register after edge N. `IntDataOut` holds its value until the next read or completion.
- Simultaneous read and completion in the same cycle: completion wins; `IntDataOut` ← result.
- Error bit: cleared only by a successful start (opcode 0x10–0x13 accepted in IDLE) or by `Reset`.
- `Reset` asserted mid-operation: abort immediately and return every register to its reset value.

Decomposition:
- Package `int_alu_pkg`:
  - Opcode enum: OP_ADD 0x10, OP_SUB 0x11, OP_CONV 0x12, OP_MUL 0x13.
  - Offset constants: OFF_SRC1, OFF_SRC2, OFF_RESULT, OFF_CMD.
  - State enum.
  - `IntAlu` select constant, 5.
- One sub-module: `int_alu_lane_unit`. It is combinational and takes two 256-bit operands plus an opcode, returning lane-wise add/sub/mul. The CONV datapath stays in the top level.

Test Plan:
- ADD: SRC1 = 0x0001_0002_0003_0004, SRC2 = 0x0008_0007_0006_0005, write 0x10 to offset 3 → one cycle later `IntDataOut` = 0x0009_0009_0009_0009 and `Done` = 1.
- SUB: SRC1 = 0x0011_0010_000F_000E, SRC2 = 0x0008_0007_0006_0005, opcode 0x11 → 0x0009_0009_0009_0009. Also SRC1 lane0 = 0x0000, SRC2 lane0 = 0x0001 → lane0 = 0xFFFF with lane1 unaffected.
- CONV: SRC1 = 0x0009_0009_0009_0009, SRC2 = 0x0001_0002_0003_0004, opcode 0x12 → `Busy` high for 16 cycles, then `IntDataOut` = 0x0009_001B_0036_005A_0051_003F_0024.
- Wrap: ADD with SRC1 lane3 = 0xFFFF and SRC2 lane3 = 0x0001 → lane3 = 0x0000 and lane4 unchanged.
- Protocol errors:
  - During CONV, write SRC1 = 0xDEAD → SRC1 unchanged (read offset 0), status bit 10 = 1.
  - Opcode 0x7F → RESULT = 0, done = 1, error = 1.
  - Read with a non-matching select (`address[15:12]` = 1) → `IntDataOut` unchanged.
- Reset mid-CONV: assert `Reset` at cycle 5 → `Busy`, `Done`, `IntDataOut`, SRC1 and SRC2 are all 0 immediately. The next ADD then works normally.

Source files
------------

// File: rtl/int_alu_pkg.sv
// Shared types and constants for the memory-mapped integer ALU responder.
package int_alu_pkg;

  localparam logic [3:0] IntAlu = 4'd5;

  typedef enum logic [7:0] {
    OP_ADD  = 8'h10,
    OP_SUB  = 8'h11,
    OP_CONV = 8'h12,
    OP_MUL  = 8'h13
  } alu_op_e;

  localparam logic [11:0] OFF_SRC1   = 12'd0;
  localparam logic [11:0] OFF_SRC2   = 12'd1;
  localparam logic [11:0] OFF_RESULT = 12'd2;
  localparam logic [11:0] OFF_CMD    = 12'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CONV = 2'd2
  } alu_state_e;

  // Low bits of the status word: {error, done, busy, last opcode}.
  function automatic logic [10:0] status_bits(input logic [7:0] op, input logic busy,
                                              input logic done, input logic err);
    return {err, done, busy, op};
  endfunction

endpackage

// File: rtl/int_alu_lane_unit.sv
// Combinational lane-wise add/sub/mul over two packed multi-lane operands.
module int_alu_lane_unit
  import int_alu_pkg::*;
#(
  parameter int LANES  = 16,
  parameter int LANE_W = 16
) (
  input  logic [LANES*LANE_W-1:0] i_a,
  input  logic [LANES*LANE_W-1:0] i_b,
  input  logic [7:0]              i_op,
  output logic [LANES*LANE_W-1:0] o_result
);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [LANE_W-1:0] w_a;
    logic [LANE_W-1:0] w_b;
    logic [LANE_W-1:0] w_res;

    assign w_a = i_a[g*LANE_W +: LANE_W];
    assign w_b = i_b[g*LANE_W +: LANE_W];

    // Per-lane operation; lane-width context keeps every result modulo 2^LANE_W.
    always_comb begin
      case (i_op)
        OP_ADD:  w_res = w_a + w_b;
        OP_SUB:  w_res = w_a - w_b;
        OP_MUL:  w_res = w_a * w_b;
        default: w_res = {LANE_W{1'b0}};
      endcase
    end

    assign o_result[g*LANE_W +: LANE_W] = w_res;
  end

endmodule

// File: rtl/int_alu_responder.sv
// Bus-slave integer ALU: two source registers, one-cycle lane-wise add/sub/mul
// and a sixteen-cycle lane convolution, with a status register at offset 3.
module int_alu_responder
  import int_alu_pkg::*;
#(
  parameter logic [3:0] SEL_ID = IntAlu,
  parameter int         LANES  = 16,
  parameter int         LANE_W = 16
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [15:0]             address,
  input  logic                    nWrite,
  input  logic                    nRead,
  input  logic [LANES*LANE_W-1:0] DataIn,
  output logic [LANES*LANE_W-1:0] IntDataOut,
  output logic                    Busy,
  output logic                    Done
);

  localparam int DATA_W = LANES * LANE_W;

  alu_state_e        r_state, w_state_nxt;
  logic [DATA_W-1:0] r_src1, r_src2, r_result, r_acc;
  logic [DATA_W-1:0] w_src1_nxt, w_src2_nxt, w_result_nxt, w_acc_nxt, w_dout_nxt;
  logic [7:0]        r_opcode, w_opcode_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic              r_err, w_err_nxt, w_busy_nxt, w_done_nxt;

  logic              w_sel, w_wr, w_rd;
  logic [11:0]       w_off;
  logic [DATA_W-1:0] w_rd_data, w_lane_res, w_b_shift, w_acc_sum;
  logic [LANE_W-1:0] w_a_sel;
  logic [31:0]       w_shamt;

  assign w_sel = (address[15:12] == SEL_ID);
  assign w_wr  = w_sel && !nWrite;
  assign w_rd  = w_sel && nWrite && !nRead;
  assign w_off = address[11:0];

  int_alu_lane_unit #(
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_lane_unit (
    .i_a      (r_src1),
    .i_b      (r_src2),
    .i_op     (r_opcode),
    .o_result (w_lane_res)
  );

  // One convolution step: a[cnt] times every lane of b, placed cnt lanes higher.
  assign w_shamt   = 32'(r_cnt) * 32'(LANE_W);
  assign w_a_sel   = r_src1[w_shamt +: LANE_W];
  assign w_b_shift = r_src2 << w_shamt;

  for (genvar g = 0; g < LANES; g++) begin : g_conv
    assign w_acc_sum[g*LANE_W +: LANE_W] =
      r_acc[g*LANE_W +: LANE_W] + w_a_sel * w_b_shift[g*LANE_W +: LANE_W];
  end

  // Read view of the register map.
  always_comb begin
    w_rd_data = {DATA_W{1'b0}};
    case (w_off)
      OFF_SRC1:   w_rd_data = r_src1;
      OFF_SRC2:   w_rd_data = r_src2;
      OFF_RESULT: w_rd_data = r_result;
      OFF_CMD:    w_rd_data = {{(DATA_W-11){1'b0}}, status_bits(r_opcode, Busy, Done, r_err)};
      default:    w_rd_data = {DATA_W{1'b0}};
    endcase
  end

  // Next-state and datapath update; completion overrides a same-cycle read.
  always_comb begin
    w_state_nxt  = r_state;
    w_src1_nxt   = r_src1;
    w_src2_nxt   = r_src2;
    w_result_nxt = r_result;
    w_acc_nxt    = r_acc;
    w_opcode_nxt = r_opcode;
    w_cnt_nxt    = r_cnt;
    w_err_nxt    = r_err;
    w_busy_nxt   = Busy;
    w_done_nxt   = Done;
    if (w_rd) begin
      w_dout_nxt = w_rd_data;
    end else begin
      w_dout_nxt = IntDataOut;
    end
    case (r_state)
      ST_IDLE: begin
        if (w_wr) begin
          case (w_off)
            OFF_SRC1: w_src1_nxt = DataIn;
            OFF_SRC2: w_src2_nxt = DataIn;
            OFF_CMD: begin
              w_opcode_nxt = DataIn[7:0];
              case (DataIn[7:0])
                OP_ADD, OP_SUB, OP_MUL: begin
                  w_state_nxt = ST_EXEC;
                  w_busy_nxt  = 1'b1;
                  w_done_nxt  = 1'b0;
                  w_err_nxt   = 1'b0;
                end
                OP_CONV: begin
                  w_state_nxt = ST_CONV;
                  w_cnt_nxt   = 4'd0;
                  w_acc_nxt   = {DATA_W{1'b0}};
                  w_busy_nxt  = 1'b1;
                  w_done_nxt  = 1'b0;
                  w_err_nxt   = 1'b0;
                end
                default: begin
                  w_result_nxt = {DATA_W{1'b0}};
                  w_done_nxt   = 1'b1;
                  w_err_nxt    = 1'b1;
                end
              endcase
            end
            default: w_state_nxt = ST_IDLE;
          endcase
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (w_wr) begin
          w_err_nxt = 1'b1;
        end else begin
          w_err_nxt = r_err;
        end
        w_result_nxt = w_lane_res;
        w_dout_nxt   = w_lane_res;
        w_busy_nxt   = 1'b0;
        w_done_nxt   = 1'b1;
        w_state_nxt  = ST_IDLE;
      end
      ST_CONV: begin
        if (w_wr) begin
          w_err_nxt = 1'b1;
        end else begin
          w_err_nxt = r_err;
        end
        w_acc_nxt = w_acc_sum;
        w_cnt_nxt = r_cnt + 4'd1;
        if (r_cnt == 4'd15) begin
          w_result_nxt = w_acc_sum;
          w_dout_nxt   = w_acc_sum;
          w_busy_nxt   = 1'b0;
          w_done_nxt   = 1'b1;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_state_nxt = ST_CONV;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_src1     <= {DATA_W{1'b0}};
      r_src2     <= {DATA_W{1'b0}};
      r_result   <= {DATA_W{1'b0}};
      r_acc      <= {DATA_W{1'b0}};
      r_opcode   <= 8'd0;
      r_cnt      <= 4'd0;
      r_err      <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      IntDataOut <= {DATA_W{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_src1     <= w_src1_nxt;
      r_src2     <= w_src2_nxt;
      r_result   <= w_result_nxt;
      r_acc      <= w_acc_nxt;
      r_opcode   <= w_opcode_nxt;
      r_cnt      <= w_cnt_nxt;
      r_err      <= w_err_nxt;
      Busy       <= w_busy_nxt;
      Done       <= w_done_nxt;
      IntDataOut <= w_dout_nxt;
    end
  end

endmodule

// File: tb/tb_int_alu_responder.sv
// Self-checking bench for int_alu_responder: directed cases plus randomized
// operations checked against a lane-array reference model.
module tb_int_alu_responder;
  import int_alu_pkg::*;

  localparam logic [3:0] SEL = 4'd5;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [15:0]  address;
  logic         nWrite, nRead;
  logic [255:0] DataIn, IntDataOut;
  logic         Busy, Done;

  int n_cmp = 0;
  int n_err = 0;

  logic [255:0] m_src1, m_src2, m_result, m_dout;
  logic [7:0]   m_op;
  logic         m_done, m_err;

  logic [255:0] t_a, t_b, t_r;
  logic [7:0]   t_op;
  int           t_n, t_sel;

  int_alu_responder dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .address    (address),
    .nWrite     (nWrite),
    .nRead      (nRead),
    .DataIn     (DataIn),
    .IntDataOut (IntDataOut),
    .Busy       (Busy),
    .Done       (Done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] ref_calc(input logic [7:0] op, input logic [255:0] a,
                                            input logic [255:0] b);
    longint unsigned la[16], lb[16], r[16];
    logic [255:0] res;
    for (int i = 0; i < 16; i++) begin
      la[i] = a[i*16 +: 16];
      lb[i] = b[i*16 +: 16];
      r[i]  = 0;
    end
    for (int k = 0; k < 16; k++) begin
      case (op)
        8'h10: r[k] = la[k] + lb[k];
        8'h11: r[k] = la[k] + 65536 - lb[k];
        8'h13: r[k] = la[k] * lb[k];
        8'h12: for (int i = 0; i <= k; i++) r[k] += la[i] * lb[k-i];
        default: r[k] = 0;
      endcase
      res[k*16 +: 16] = 16'(r[k] % 65536);
    end
    return res;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [255:0] exp_status();
    return {245'd0, m_err, m_done, 1'b0, m_op};
  endfunction

  task automatic m_clear();
    m_src1 = '0; m_src2 = '0; m_result = '0; m_dout = '0;
    m_op = 8'd0; m_done = 1'b0; m_err = 1'b0;
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic bus_write(input logic [11:0] off, input logic [255:0] d);
    address = {SEL, off}; DataIn = d; nWrite = 1'b0; nRead = 1'b1;
    cyc();
    nWrite = 1'b1; address = 16'h0000;
  endtask

  task automatic read_chk(input logic [11:0] off, input logic [255:0] exp, input string tag);
    address = {SEL, off}; nRead = 1'b0;
    cyc();
    nRead = 1'b1; address = 16'h0000;
    m_dout = exp;
    check(tag, IntDataOut, exp);
  endtask

  task automatic set_srcs(input logic [255:0] a, input logic [255:0] b);
    bus_write(OFF_SRC1, a); m_src1 = a;
    bus_write(OFF_SRC2, b); m_src2 = b;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (Busy && n < 40) begin
      cyc();
      n++;
    end
  endtask

  task automatic run_op(input logic [7:0] op, input string tag);
    int n;
    logic [255:0] r;
    bus_write(OFF_CMD, {248'd0, op});
    if (op >= 8'h10 && op <= 8'h13) begin
      r = ref_calc(op, m_src1, m_src2);
      check({tag, "/busy"}, Busy, 1'b1);
      wait_done(n);
      check({tag, "/lat"}, n, (op == 8'h12) ? 16 : 1);
      m_result = r; m_dout = r; m_op = op; m_done = 1'b1; m_err = 1'b0;
      check({tag, "/done"}, Done, 1'b1);
      check({tag, "/out"}, IntDataOut, r);
    end else begin
      m_result = '0; m_op = op; m_done = 1'b1; m_err = 1'b1;
      check({tag, "/busy"}, Busy, 1'b0);
      check({tag, "/done"}, Done, 1'b1);
      check({tag, "/hold"}, IntDataOut, m_dout);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1; address = 16'h0000; nWrite = 1'b1; nRead = 1'b1; DataIn = '0;
    m_clear();
    repeat (2) @(posedge Clk);
    #1;
    check("rst/out", IntDataOut, 256'd0);
    check("rst/busy", Busy, 1'b0);
    check("rst/done", Done, 1'b0);
    Reset = 1'b0;
    read_chk(OFF_CMD, exp_status(), "rst/status");
    read_chk(OFF_SRC1, 256'd0, "rst/src1");

    set_srcs(256'h0001_0002_0003_0004, 256'h0008_0007_0006_0005);
    run_op(8'h10, "add");
    check("add/lit", IntDataOut, 256'h0009_0009_0009_0009);

    set_srcs(256'h0011_0010_000F_000E, 256'h0008_0007_0006_0005);
    run_op(8'h11, "sub");
    check("sub/lit", IntDataOut, 256'h0009_0009_0009_0009);

    set_srcs(256'h0000_0000_0005_0000, 256'h0000_0000_0002_0001);
    run_op(8'h11, "borrow");
    check("borrow/lit", IntDataOut, 256'h0000_0000_0003_FFFF);

    set_srcs(256'h0007_FFFF_0000_0000_0000, 256'h0000_0001_0000_0000_0000);
    run_op(8'h10, "wrap");
    check("wrap/lit", IntDataOut, 256'h0007_0000_0000_0000_0000);

    set_srcs(256'h0009_0009_0009_0009, 256'h0001_0002_0003_0004);
    run_op(8'h12, "conv");
    check("conv/lit", IntDataOut, 256'h0009_001B_0036_005A_0051_003F_0024);

    // Write during a convolution is dropped and flags the error bit.
    bus_write(OFF_CMD, 256'h12);
    check("intr/busy", Busy, 1'b1);
    bus_write(OFF_SRC1, 256'hDEAD);
    wait_done(t_n);
    check("intr/lat", t_n, 15);
    t_r = ref_calc(8'h12, m_src1, m_src2);
    m_result = t_r; m_dout = t_r; m_op = 8'h12; m_done = 1'b1; m_err = 1'b1;
    check("intr/out", IntDataOut, t_r);
    read_chk(OFF_SRC1, m_src1, "intr/src1");
    read_chk(OFF_CMD, exp_status(), "intr/status");

    run_op(8'h7F, "badop");
    read_chk(OFF_RESULT, 256'd0, "badop/result");
    read_chk(OFF_CMD, exp_status(), "badop/status");

    address = {4'd1, OFF_SRC1}; nRead = 1'b0;
    cyc();
    nRead = 1'b1; address = 16'h0000;
    check("nosel/hold", IntDataOut, m_dout);

    // Asynchronous reset in the middle of a convolution.
    set_srcs(rand256(), rand256());
    bus_write(OFF_CMD, 256'h12);
    repeat (4) cyc();
    Reset = 1'b1;
    #1;
    check("mrst/busy", Busy, 1'b0);
    check("mrst/done", Done, 1'b0);
    check("mrst/out", IntDataOut, 256'd0);
    @(negedge Clk);
    Reset = 1'b0;
    cyc();
    m_clear();
    read_chk(OFF_SRC1, 256'd0, "mrst/src1");
    read_chk(OFF_SRC2, 256'd0, "mrst/src2");
    read_chk(OFF_CMD, exp_status(), "mrst/status");
    set_srcs(256'h0001_0002_0003_0004, 256'h0008_0007_0006_0005);
    run_op(8'h10, "mrst/add");
    check("mrst/lit", IntDataOut, 256'h0009_0009_0009_0009);

    for (int it = 0; it < 40; it++) begin
      t_a = rand256();
      t_b = rand256();
      set_srcs(t_a, t_b);
      t_sel = $urandom_range(0, 9);
      case (t_sel)
        0, 1, 9: t_op = 8'h10;
        2, 3:    t_op = 8'h11;
        4, 5:    t_op = 8'h13;
        6, 7:    t_op = 8'h12;
        default: begin
          t_op = 8'($urandom_range(0, 255));
          if (t_op >= 8'h10 && t_op <= 8'h13) t_op = 8'hA5;
        end
      endcase
      run_op(t_op, "rand");
      read_chk(OFF_RESULT, m_result, "rand/result");
      if (it % 4 == 0) read_chk(OFF_CMD, exp_status(), "rand/status");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
